pwm_capture: RTL
================

# pwm_capture

PWM input-capture block: the receive-side counterpart to the team's Wishbone PWM/timer generator. It samples an external PWM waveform in the `i_clk` domain and measures period and high time in `i_clk` cycles. It exposes the results through the same 16-bit Wishbone slave register map style. It also drives a `o_dc`/`o_dc_valid` pair that can feed a generator's external duty-cycle input directly.

## Interface
- `CNT_W`, 16: measurement counter width; `CNT_W` ≤ 16, registers zero-extended to 16 bits
- `SYNC_STAGES`, 2: synchronizer flops on `i_pwm`; minimum 2
- `i_clk`  in  1  system/Wishbone clock
- `i_rst`  in  1  reset, asynchronous, active-low
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we`  in  1 each  Wishbone slave controls
- `i_wb_adr`  in  4  byte address; word select = `i_wb_adr[3:1]`
- `i_wb_data`  in  16  write data
- `o_wb_ack`  out  1  Wishbone acknowledge
- `o_wb_data`  out  16  read data
- `i_pwm`  in  1  asynchronous PWM input
- `o_dc`  out  16  last captured high time
- `o_dc_valid`  out  1  one-cycle pulse when `o_dc`/period update
- `o_irq`  out  1  level interrupt

## Operation
- Register map, by `i_wb_adr[3:1]`:
  - 0 CTRL, RW: bit0 `enable`, bit1 `irq_en`, bit2 `one_shot`
  - 1 STATUS: bit0 `valid`, bit1 `overflow`, both write-1-to-clear; bit2 `busy` (RO, FSM ≠ IDLE)
  - 2 PERIOD, RO
  - 3 HIGH, RO
  - 4–7 read 0; writes to RO or unmapped addresses are ignored
- Input path: `i_pwm` passes through `SYNC_STAGES` flops, then one history flop. `rise` = sync & ~hist; `fall` = ~sync & hist.
- FSM states IDLE, ARM, HIGH, LOW; counter `cnt` is `CNT_W` bits:
  - IDLE: `cnt` = 0. Go to ARM when `enable` = 1.
  - ARM: wait for `rise`. On `rise`: `cnt` <= 1, go to HIGH.
  - HIGH: `cnt` <= `cnt`+1 each cycle. On `fall`: `high_cap` <= `cnt`, go to LOW.
  - LOW: `cnt` <= `cnt`+1. On `rise`:
    - PERIOD <= `cnt`; HIGH <= `high_cap`; `valid` <= 1; `o_dc_valid` pulses
    - `cnt` <= 1, go to HIGH
    - if `one_shot`: clear `enable` instead and go to IDLE
- Result: for input high H cycles and low L cycles, PERIOD = H+L and HIGH = H. The synchronizer delay cancels out.
- Overflow: if `cnt` = 2^CNT_W−1 in HIGH or LOW without the expected edge, set `overflow`, go to ARM, and leave PERIOD/HIGH unchanged. This covers stuck-high and stuck-low inputs.
- `enable` cleared while in any state: next state is IDLE and `cnt` <= 0. PERIOD, HIGH and STATUS are retained.
- `o_irq` = `irq_en` & (`valid` | `overflow`).
- A capture or overflow event in the same cycle as a W1C write of that bit: the set wins.
- A CTRL write and a one-shot auto-clear in the same cycle: the Wishbone write wins.

## Timing
- Reset values: `o_wb_ack` 0, `o_wb_data` 0, `o_dc` 0, `o_dc_valid` 0, `o_irq` 0. All registers, synchronizer and FSM reset to 0/IDLE asynchronously.
- Wishbone bus cycle:
  - `o_wb_ack` <= `i_wb_cyc` & `i_wb_stb` & ~`o_wb_ack`, giving one ack per request and a 1-cycle latency.
  - Read data is registered in the same edge as ack.
  - A write takes effect at the ack edge.
- Edge-to-detect latency: `SYNC_STAGES`+1 cycles from an `i_pwm` transition to `rise`/`fall`.
- PERIOD, HIGH, `o_dc`, STATUS.`valid` and `o_dc_valid` all update on the clock edge after the capturing `rise` cycle.
- `o_irq` is registered and follows `valid` one cycle later.
- Minimum measurable high or low phase: 1 cycle at the synchronizer output. Shorter input pulses may be lost; this is not an error.

## Test plan
1. Reset: pulse `i_rst` low mid-HIGH-state -> all outputs 0 immediately; STATUS reads 0, PERIOD reads 0, FSM returns to IDLE.
2. Capture: CTRL=0x1; `i_pwm` 300 high / 700 low, repeating -> after the second rise, PERIOD=1000, HIGH=300, `o_dc`=300, single `o_dc_valid` pulse, STATUS=0x5. Values repeat every 1000 cycles.
3. Overflow (`CNT_W`=8): hold `i_pwm` high after a rise -> 255 cycles later STATUS.`overflow`=1, FSM in ARM, PERIOD unchanged. With `irq_en` set, `o_irq`=1; writing STATUS=0x2 clears it.
4. One-shot: CTRL=0x5 with a 40/60 waveform -> exactly one capture (PERIOD=100, HIGH=40), CTRL reads 0x4, `busy`=0, no further `o_dc_valid`.
5. W1C race: write STATUS=0x1 in the same cycle as a capture -> `valid` reads 1 afterwards.
6. Wishbone: back-to-back reads of addresses 2, 3, 6 with `stb` held -> ack on alternate cycles with data PERIOD, HIGH, 0; write to address 2 -> PERIOD unchanged.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of an asynchronous PWM input
// in i_clk cycles and reports them through a 16-bit Wishbone register window.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_adr,
  input  logic [15:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [15:0] o_wb_data,
  input  logic        i_pwm,
  output logic [15:0] o_dc,
  output logic        o_dc_valid,
  output logic        o_irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  function automatic logic [15:0] zext(input logic [CNT_W-1:0] v);
    logic [15:0] r;
    r = 16'h0000;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic                   sync_s;
  logic                   rise_s;
  logic                   fall_s;

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic [CNT_W-1:0] high_cap_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] high_r;
  logic             capture_s;
  logic             ovf_s;
  logic             fall_cap_s;
  logic             auto_clr_s;

  logic        enable_r;
  logic        irq_en_r;
  logic        one_shot_r;
  logic        valid_r;
  logic        overflow_r;
  logic        dc_valid_r;
  logic        irq_r;
  logic        ack_r;
  logic [15:0] rdata_r;
  logic [15:0] rdata_s;

  logic       req_s;
  logic       wr_s;
  logic [2:0] word_s;
  logic       ctrl_wr_s;
  logic       stat_wr_s;
  logic       busy_s;

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign rise_s = sync_s & ~hist_r;
  assign fall_s = ~sync_s & hist_r;

  assign req_s     = i_wb_cyc & i_wb_stb & ~ack_r;
  assign wr_s      = req_s & i_wb_we;
  assign word_s    = i_wb_adr[3:1];
  assign ctrl_wr_s = wr_s & (word_s == 3'd0);
  assign stat_wr_s = wr_s & (word_s == 3'd1);
  assign busy_s    = (state_r != ST_IDLE);

  assign o_wb_ack   = ack_r;
  assign o_wb_data  = rdata_r;
  assign o_dc       = zext(high_r);
  assign o_dc_valid = dc_valid_r;
  assign o_irq      = irq_r;

  // Input synchronizer plus history flop for edge detection
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_r <= '0;
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], i_pwm};
      hist_r <= sync_s;
    end
  end

  // Measurement FSM next-state and counter logic
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    capture_s  = 1'b0;
    ovf_s      = 1'b0;
    fall_cap_s = 1'b0;
    auto_clr_s = 1'b0;
    if (!enable_r) begin
      state_nx_s = ST_IDLE;
      cnt_nx_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_ARM;
          cnt_nx_s   = CNT_ZERO;
        end
        ST_ARM: begin
          if (rise_s) begin
            state_nx_s = ST_HIGH;
            cnt_nx_s   = CNT_ONE;
          end else begin
            cnt_nx_s = CNT_ZERO;
          end
        end
        ST_HIGH: begin
          if (fall_s) begin
            fall_cap_s = 1'b1;
            state_nx_s = ST_LOW;
            cnt_nx_s   = cnt_r + CNT_ONE;
          end else if (cnt_r == CNT_MAX) begin
            ovf_s      = 1'b1;
            state_nx_s = ST_ARM;
            cnt_nx_s   = CNT_ZERO;
          end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
          end
        end
        ST_LOW: begin
          if (rise_s) begin
            capture_s = 1'b1;
            if (one_shot_r) begin
              auto_clr_s = 1'b1;
              state_nx_s = ST_IDLE;
              cnt_nx_s   = CNT_ZERO;
            end else begin
              state_nx_s = ST_HIGH;
              cnt_nx_s   = CNT_ONE;
            end
          end else if (cnt_r == CNT_MAX) begin
            ovf_s      = 1'b1;
            state_nx_s = ST_ARM;
            cnt_nx_s   = CNT_ZERO;
          end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state, counter and measurement result registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      high_cap_r <= CNT_ZERO;
      period_r   <= CNT_ZERO;
      high_r     <= CNT_ZERO;
      dc_valid_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      dc_valid_r <= capture_s;
      if (fall_cap_s) begin
        high_cap_r <= cnt_r;
      end
      if (capture_s) begin
        period_r <= cnt_r;
        high_r   <= high_cap_r;
      end
    end
  end

  // Control/status registers; hardware set beats W1C, bus write beats auto-clear
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      enable_r   <= 1'b0;
      irq_en_r   <= 1'b0;
      one_shot_r <= 1'b0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        enable_r   <= i_wb_data[0];
        irq_en_r   <= i_wb_data[1];
        one_shot_r <= i_wb_data[2];
      end else if (auto_clr_s) begin
        enable_r <= 1'b0;
      end
      if (capture_s) begin
        valid_r <= 1'b1;
      end else if (stat_wr_s && i_wb_data[0]) begin
        valid_r <= 1'b0;
      end
      if (ovf_s) begin
        overflow_r <= 1'b1;
      end else if (stat_wr_s && i_wb_data[1]) begin
        overflow_r <= 1'b0;
      end
      irq_r <= irq_en_r & (valid_r | overflow_r);
    end
  end

  // Register read multiplexer
  always_comb begin
    rdata_s = 16'h0000;
    case (word_s)
      3'd0:    rdata_s = {13'h0000, one_shot_r, irq_en_r, enable_r};
      3'd1:    rdata_s = {13'h0000, busy_s, overflow_r, valid_r};
      3'd2:    rdata_s = zext(period_r);
      3'd3:    rdata_s = zext(high_r);
      default: rdata_s = 16'h0000;
    endcase
  end

  // Wishbone acknowledge and registered read data
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ack_r   <= 1'b0;
      rdata_r <= 16'h0000;
    end else begin
      ack_r <= req_s;
      if (req_s) begin
        rdata_r <= rdata_s;
      end
    end
  end

endmodule
